alu_op_responder: RTL

//   Request/response execution unit for ALU operations. Accepts one operation
//   (opcode + two operands) on a valid/ready request port, executes it, and

---
 rtl/alu_op_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_op_responder.sv
// alu_op_responder: valid/ready ALU execution unit.
// Single-cycle ADD/SUB/AND/OR. SLL/SRA are bit-serial: one bit position per clock.
module alu_op_responder #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               isNotEqual,
  output logic               isLessThan
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t             r_state, w_next;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_ovf, r_ne, r_lt;

  logic               w_is_sub, w_is_shift;
  logic [WIDTH-1:0]   w_binv, w_sum;
  logic               w_add_ovf;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf, w_ne, w_lt;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == '0) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Adder shared by ADD and SUB (SUB = A + ~B + 1)
  always_comb begin
    w_is_sub  = (r_op == OP_SUB);
    w_binv    = w_is_sub ? ~r_b : r_b;
    w_sum     = r_a + w_binv + WIDTH'(w_is_sub);
    w_add_ovf = (r_a[WIDTH-1] == w_binv[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Final result/flags selection; shifts already sit fully shifted in r_a
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ne  = 1'b0;
    w_lt  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      OP_SUB: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
        w_ne  = |w_sum;
        w_lt  = w_sum[WIDTH-1] ^ w_add_ovf;
      end
      OP_AND:         w_res = r_a & r_b;
      OP_OR:          w_res = r_a | r_b;
      OP_SLL, OP_SRA: w_res = r_a;
      default:        w_res = '0;
    endcase
  end

  assign w_is_shift = (opcode == OP_SLL) || (opcode == OP_SRA);

  // Operand capture, serial shifting and result registration
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_ne     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op  <= opcode;
            r_a   <= in1;
            r_b   <= in2;
            r_cnt <= w_is_shift ? shamt : '0;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
            r_ne     <= w_ne;
            r_lt     <= w_lt;
          end else begin
            // Only shifts ever load a non-zero count
            if (r_op == OP_SRA) r_a <= {r_a[WIDTH-1], r_a[WIDTH-1:1]};
            else                r_a <= {r_a[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result     = r_result;
  assign overflow   = r_ovf;
  assign isNotEqual = r_ne;
  assign isLessThan = r_lt;

endmodule
